btb_update_unit: RTL and testbench

- Writer-side companion to the branch target buffer.
- Holds the prediction made for each in-flight branch in an in-order queue, from decode until the branch resolves in execute.
- On resolution, compares actual against predicted outcome. It generates the registered BTB write port signals (write_pc, write_data, taken, write). On a mispredict it drives a fetch redirect plus a queue flush.

---
 rtl/btb_update_unit_pkg.sv | 24 ++
 rtl/btb_pred_queue.sv | 50 +++++
 rtl/btb_update_unit.sv | 140 ++++++++++++++
 tb/tb_btb_update_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/btb_update_unit_pkg.sv
// Shared types for the BTB update path: the LC-3b word, the per-branch
// prediction record and the RUN/FLUSH state encoding.
package btb_update_unit_pkg;

    typedef logic [15:0] lc3b_word;

    localparam int BTB_UPD_DEPTH = 4;

    typedef struct packed {
        lc3b_word pc;
        logic     hit;
        lc3b_word pred_pc;
    } lc3b_btb_rec;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } btb_upd_state_t;

    function automatic lc3b_word fallthrough(input lc3b_word pc);
        return pc + 16'd2;
    endfunction

endpackage

// File: rtl/btb_pred_queue.sv
// In-order circular FIFO of branch prediction records. Flush empties the
// queue and takes priority over a simultaneous push or pop.
module btb_pred_queue
    import btb_update_unit_pkg::*;
#(
    parameter int DEPTH = BTB_UPD_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  lc3b_btb_rec i_push_rec,
    input  logic        i_pop,
    input  logic        i_flush,
    output lc3b_btb_rec o_head_rec,
    output logic [AW:0] o_count
);

    lc3b_btb_rec   r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;
    logic          w_push;

    assign w_push = i_push && !i_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= r_tail;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + AW'(1);
            if (i_pop)  r_head <= r_head + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(i_pop);
        end
    end

    // Storage needs no reset; validity is tracked entirely by r_count.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_tail] <= i_push_rec;
    end

    assign o_head_rec = r_mem[r_head];
    assign o_count    = r_count;

endmodule

// File: rtl/btb_update_unit.sv
// Resolves in-flight branch predictions, drives BTB writes and fetch redirects.
// Optional BTB_UPDATE_STATS_EN adds saturating branch/mispredict counters.
//
// state    | meaning
// ST_RUN   | normal operation, decode may enqueue
// ST_FLUSH | post-redirect bubble, enqueue blocked for FLUSH_CYCLES cycles
module btb_update_unit
    import btb_update_unit_pkg::*;
#(
    parameter int DEPTH        = BTB_UPD_DEPTH,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     enq_valid,
    input  lc3b_word enq_pc,
    input  logic     enq_hit,
    input  lc3b_word enq_pred_pc,
    output logic     enq_ready,
    input  logic     res_valid,
    input  logic     res_taken,
    input  lc3b_word res_target,
    output logic     btb_write,
    output logic     btb_taken,
    output lc3b_word btb_write_pc,
    output lc3b_word btb_write_data,
    output logic     redirect_valid,
    output lc3b_word redirect_pc,
    output logic     res_underflow
`ifdef BTB_UPDATE_STATS_EN
    ,
    output logic [15:0] branch_count,
    output logic [15:0] mispredict_count
`endif
);

    localparam int          AW   = $clog2(DEPTH);
    localparam int          FCW  = $clog2(FLUSH_CYCLES + 1);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    btb_upd_state_t r_state, w_state_nxt;
    logic [FCW-1:0] r_flush_cnt, w_flush_cnt_nxt;

    lc3b_btb_rec w_head;
    lc3b_btb_rec w_enq_rec;
    logic [AW:0] w_count;
    logic        w_pop, w_misp, w_upd, w_push;

    logic     r_btb_write, r_redirect_valid, r_underflow;
    lc3b_word r_btb_pc, r_btb_data, r_redirect_pc;

    assign w_enq_rec = '{pc: enq_pc, hit: enq_hit, pred_pc: enq_pred_pc};

    assign enq_ready = (r_state == ST_RUN) && ((w_count < FULL) || res_valid);
    assign w_pop     = res_valid && (w_count != '0);
    assign w_misp    = w_pop && ((w_head.hit != res_taken) ||
                                 (w_head.hit && res_taken && w_head.pred_pc != res_target));
    assign w_upd     = w_pop && res_taken && (!w_head.hit || w_head.pred_pc != res_target);
    // A mispredict makes any same-cycle enqueue wrong-path; the flush drops it.
    assign w_push    = enq_valid && enq_ready;

    btb_pred_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_rec (w_enq_rec),
        .i_pop      (w_pop),
        .i_flush    (w_misp),
        .o_head_rec (w_head),
        .o_count    (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        if (w_misp) begin
            w_state_nxt     = ST_FLUSH;
            w_flush_cnt_nxt = FCW'(FLUSH_CYCLES - 1);
        end else if (r_state == ST_FLUSH) begin
            if (r_flush_cnt == '0) w_state_nxt = ST_RUN;
            else                   w_flush_cnt_nxt = r_flush_cnt - FCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_btb_write      <= 1'b0;
            r_btb_pc         <= '0;
            r_btb_data       <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_underflow      <= 1'b0;
        end else begin
            r_btb_write      <= w_upd;
            r_btb_pc         <= w_upd ? w_head.pc : '0;
            r_btb_data       <= w_upd ? res_target : '0;
            r_redirect_valid <= w_misp;
            r_redirect_pc    <= w_misp ? (res_taken ? res_target : fallthrough(w_head.pc)) : '0;
            if (res_valid && (w_count == '0)) r_underflow <= 1'b1;
        end
    end

    assign btb_write      = r_btb_write;
    assign btb_taken      = r_btb_write;
    assign btb_write_pc   = r_btb_pc;
    assign btb_write_data = r_btb_data;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign res_underflow  = r_underflow;

`ifdef BTB_UPDATE_STATS_EN
    logic [15:0] r_branch_count, r_mispredict_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            if (w_pop && r_branch_count != 16'hFFFF)
                r_branch_count <= r_branch_count + 16'd1;
            if (w_misp && r_mispredict_count != 16'hFFFF)
                r_mispredict_count <= r_mispredict_count + 16'd1;
        end
    end

    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;
`endif

endmodule

// File: tb/tb_btb_update_unit.sv
// Bench for btb_update_unit: directed vector table plus randomized traffic
// against a queue-based reference model.
module tb_btb_update_unit;
    import btb_update_unit_pkg::*;

    localparam int DEPTH = 4;
    localparam int FC    = 2;

    logic     clk, rst;
    logic     enq_valid, enq_hit, enq_ready;
    lc3b_word enq_pc, enq_pred_pc;
    logic     res_valid, res_taken;
    lc3b_word res_target;
    logic     btb_write, btb_taken, redirect_valid, res_underflow;
    lc3b_word btb_write_pc, btb_write_data, redirect_pc;
`ifdef BTB_UPDATE_STATS_EN
    logic [15:0] branch_count, mispredict_count;
    int          m_bc, m_mc;
`endif

    btb_update_unit #(.DEPTH(DEPTH), .FLUSH_CYCLES(FC)) dut (
        .clk            (clk),
        .rst            (rst),
        .enq_valid      (enq_valid),
        .enq_pc         (enq_pc),
        .enq_hit        (enq_hit),
        .enq_pred_pc    (enq_pred_pc),
        .enq_ready      (enq_ready),
        .res_valid      (res_valid),
        .res_taken      (res_taken),
        .res_target     (res_target),
        .btb_write      (btb_write),
        .btb_taken      (btb_taken),
        .btb_write_pc   (btb_write_pc),
        .btb_write_data (btb_write_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .res_underflow  (res_underflow)
`ifdef BTB_UPDATE_STATS_EN
        ,
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       rst;
        bit       ev;
        lc3b_word pc;
        bit       hit;
        lc3b_word pred;
        bit       rv;
        bit       rt;
        lc3b_word tgt;
        bit       x_ready;
        bit       x_w;
        lc3b_word x_wpc;
        lc3b_word x_wd;
        bit       x_rv;
        lc3b_word x_rpc;
        bit       x_uf;
    } vec_t;

    int n_vec = 0;
    int n_fail = 0;

    // Reference model state
    lc3b_btb_rec mq[$];
    int          flush_left;
    bit          m_uf, exp_w, exp_rv;
    lc3b_word    exp_wpc, exp_wd, exp_rpc;

    function automatic vec_t V(bit r, bit ev, lc3b_word pc, bit hit, lc3b_word pred,
                               bit rv, bit rt, lc3b_word tgt, bit xr, bit xw,
                               lc3b_word xwpc, lc3b_word xwd, bit xrv, lc3b_word xrpc, bit xuf);
        vec_t v;
        v.rst = r; v.ev = ev; v.pc = pc; v.hit = hit; v.pred = pred;
        v.rv = rv; v.rt = rt; v.tgt = tgt; v.x_ready = xr; v.x_w = xw;
        v.x_wpc = xwpc; v.x_wd = xwd; v.x_rv = xrv; v.x_rpc = xrpc; v.x_uf = xuf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready(input bit rv);
        return (flush_left == 0) && ((mq.size() < DEPTH) || rv);
    endfunction

    task automatic model_reset();
        mq.delete();
        flush_left = 0; m_uf = 0;
        exp_w = 0; exp_wpc = '0; exp_wd = '0; exp_rv = 0; exp_rpc = '0;
`ifdef BTB_UPDATE_STATS_EN
        m_bc = 0; m_mc = 0;
`endif
    endtask

    task automatic model_edge(input vec_t v);
        bit          rdy, misp;
        lc3b_btb_rec r;
        rdy  = model_ready(v.rv);
        misp = 0;
        if (v.rst) begin
            model_reset();
            return;
        end
        exp_w = 0; exp_rv = 0; exp_wpc = '0; exp_wd = '0; exp_rpc = '0;
        if (v.rv) begin
            if (mq.size() == 0) m_uf = 1;
            else begin
                r = mq.pop_front();
`ifdef BTB_UPDATE_STATS_EN
                if (m_bc < 65535) m_bc++;
`endif
                misp = (r.hit != v.rt) || (r.hit && v.rt && r.pred_pc != v.tgt);
                if (v.rt && (!r.hit || r.pred_pc != v.tgt)) begin
                    exp_w = 1; exp_wpc = r.pc; exp_wd = v.tgt;
                end
                if (misp) begin
                    exp_rv  = 1;
                    exp_rpc = v.rt ? v.tgt : lc3b_word'(r.pc + 16'd2);
                    mq.delete();
`ifdef BTB_UPDATE_STATS_EN
                    if (m_mc < 65535) m_mc++;
`endif
                end
            end
        end
        if (v.ev && rdy && !misp) mq.push_back('{pc: v.pc, hit: v.hit, pred_pc: v.pred});
        if (misp) flush_left = FC;
        else if (flush_left > 0) flush_left--;
    endtask

    task automatic apply(input vec_t v, input bit use_tab);
        @(negedge clk);
        rst = v.rst; enq_valid = v.ev; enq_pc = v.pc; enq_hit = v.hit; enq_pred_pc = v.pred;
        res_valid = v.rv; res_taken = v.rt; res_target = v.tgt;
        #1;
        chk("enq_ready", 16'(enq_ready), 16'(model_ready(v.rv)));
        if (use_tab) chk("tab_enq_ready", 16'(enq_ready), 16'(v.x_ready));
        model_edge(v);
        @(posedge clk);
        #1;
        chk("btb_write", 16'(btb_write), 16'(exp_w));
        chk("btb_taken", 16'(btb_taken), 16'(exp_w));
        if (exp_w) begin
            chk("btb_write_pc", btb_write_pc, exp_wpc);
            chk("btb_write_data", btb_write_data, exp_wd);
        end
        chk("redirect_valid", 16'(redirect_valid), 16'(exp_rv));
        if (exp_rv) chk("redirect_pc", redirect_pc, exp_rpc);
        chk("res_underflow", 16'(res_underflow), 16'(m_uf));
`ifdef BTB_UPDATE_STATS_EN
        chk("branch_count", branch_count, 16'(m_bc));
        chk("mispredict_count", mispredict_count, 16'(m_mc));
`endif
        if (use_tab) begin
            chk("tab_btb_write", 16'(btb_write), 16'(v.x_w));
            if (v.x_w) begin
                chk("tab_write_pc", btb_write_pc, v.x_wpc);
                chk("tab_write_data", btb_write_data, v.x_wd);
            end
            chk("tab_redirect_valid", 16'(redirect_valid), 16'(v.x_rv));
            if (v.x_rv) chk("tab_redirect_pc", redirect_pc, v.x_rpc);
            chk("tab_underflow", 16'(res_underflow), 16'(v.x_uf));
        end
    endtask

    vec_t tab[$];

    initial begin
        vec_t v;
        lc3b_word idle_w;
        idle_w = '0;

        rst = 1; enq_valid = 0; enq_pc = '0; enq_hit = 0; enq_pred_pc = '0;
        res_valid = 0; res_taken = 0; res_target = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
        #1;
        chk("reset_enq_ready", 16'(enq_ready), 16'd1);
        chk("reset_btb_write", 16'(btb_write), 16'd0);
        chk("reset_btb_taken", 16'(btb_taken), 16'd0);
        chk("reset_write_pc", btb_write_pc, 16'h0000);
        chk("reset_redirect", 16'(redirect_valid), 16'd0);
        chk("reset_redirect_pc", redirect_pc, 16'h0000);
        chk("reset_underflow", 16'(res_underflow), 16'd0);

        // Not-predicted taken branch: write + redirect, then 2-cycle flush
        tab.push_back(V(0,1,16'h3000,0,16'h0000, 0,0,16'h0000, 1,0,idle_w,idle_w,0,idle_w,0));
        tab.push_back(V(0,0,16'h0000,0,16'h0000, 1,1,16'h3040, 1,1,16'h3000,16'h3040,1,16'h3040,0));
        tab.push_back(V(0,1,16'h3500,0,16'h0000, 0,0,16'h0000, 0,0,idle_w,idle_w,0,idle_w,0));
        tab.push_back(V(0,0,16'h0000,0,16'h0000, 0,0,16'h0000, 0,0,idle_w,idle_w,0,idle_w,0));
        // Correctly predicted taken: nothing emitted
        tab.push_back(V(0,1,16'h3010,1,16'h3050, 0,0,16'h0000, 1,0,idle_w,idle_w,0,idle_w,0));
        tab.push_back(V(0,0,16'h0000,0,16'h0000, 1,1,16'h3050, 1,0,idle_w,idle_w,0,idle_w,0));
        // Predicted taken, actually not taken: redirect to fallthrough only
        tab.push_back(V(0,1,16'h3020,1,16'h3060, 0,0,16'h0000, 1,0,idle_w,idle_w,0,idle_w,0));
        tab.push_back(V(0,0,16'h0000,0,16'h0000, 1,0,16'h0000, 1,0,idle_w,idle_w,1,16'h3022,0));
        tab.push_back(V(0,1,16'h3510,0,16'h0000, 0,0,16'h0000, 0,0,idle_w,idle_w,0,idle_w,0));
        tab.push_back(V(0,0,16'h0000,0,16'h0000, 0,0,16'h0000, 0,0,idle_w,idle_w,0,idle_w,0));
        // Fill, stall on full, then enq+res together
        for (int i = 0; i < 4; i++)
            tab.push_back(V(0,1,16'h3100 + 16'(2*i),0,16'h0000, 0,0,16'h0000, 1,0,idle_w,idle_w,0,idle_w,0));
        tab.push_back(V(0,1,16'h3108,0,16'h0000, 0,0,16'h0000, 0,0,idle_w,idle_w,0,idle_w,0));
        tab.push_back(V(0,1,16'h3108,0,16'h0000, 1,0,16'h0000, 1,0,idle_w,idle_w,0,idle_w,0));
        for (int i = 0; i < 4; i++)
            tab.push_back(V(0,0,16'h0000,0,16'h0000, 1,0,16'h0000, 1,0,idle_w,idle_w,0,idle_w,0));
        // Hit and taken but wrong target: write and redirect
        tab.push_back(V(0,1,16'h3400,1,16'h3450, 0,0,16'h0000, 1,0,idle_w,idle_w,0,idle_w,0));
        tab.push_back(V(0,0,16'h0000,0,16'h0000, 1,1,16'h3460, 1,1,16'h3400,16'h3460,1,16'h3460,0));
        tab.push_back(V(0,0,16'h0000,0,16'h0000, 0,0,16'h0000, 0,0,idle_w,idle_w,0,idle_w,0));
        tab.push_back(V(0,0,16'h0000,0,16'h0000, 0,0,16'h0000, 0,0,idle_w,idle_w,0,idle_w,0));
        // Mispredict with a simultaneous enqueue: enqueue dropped, queue empty
        for (int i = 0; i < 3; i++)
            tab.push_back(V(0,1,16'h3200 + 16'(2*i),0,16'h0000, 0,0,16'h0000, 1,0,idle_w,idle_w,0,idle_w,0));
        tab.push_back(V(0,1,16'h3206,0,16'h0000, 1,1,16'h3300, 1,1,16'h3200,16'h3300,1,16'h3300,0));
        tab.push_back(V(0,0,16'h0000,0,16'h0000, 0,0,16'h0000, 0,0,idle_w,idle_w,0,idle_w,0));
        tab.push_back(V(0,0,16'h0000,0,16'h0000, 0,0,16'h0000, 0,0,idle_w,idle_w,0,idle_w,0));
        tab.push_back(V(0,0,16'h0000,0,16'h0000, 1,0,16'h0000, 1,0,idle_w,idle_w,0,idle_w,1));
        tab.push_back(V(0,0,16'h0000,0,16'h0000, 0,0,16'h0000, 1,0,idle_w,idle_w,0,idle_w,1));
        // PC wrap on fallthrough, then reset in the middle of the flush
        tab.push_back(V(0,1,16'hFFFE,1,16'h0100, 0,0,16'h0000, 1,0,idle_w,idle_w,0,idle_w,1));
        tab.push_back(V(0,0,16'h0000,0,16'h0000, 1,0,16'h0000, 1,0,idle_w,idle_w,1,16'h0000,1));
        tab.push_back(V(1,0,16'h0000,0,16'h0000, 0,0,16'h0000, 0,0,idle_w,idle_w,0,idle_w,0));
        tab.push_back(V(0,0,16'h0000,0,16'h0000, 0,0,16'h0000, 1,0,idle_w,idle_w,0,idle_w,0));

        foreach (tab[i]) apply(tab[i], 1'b1);

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            v = V(0,0,16'h0,0,16'h0,0,0,16'h0,0,0,16'h0,16'h0,0,16'h0,0);
            v.rst = ($urandom_range(0, 99) == 0);
            v.ev  = ($urandom_range(0, 9) < 6);
            v.pc  = 16'($urandom) & 16'hFFFE;
            if ($urandom_range(0, 19) == 0) v.pc = 16'hFFFE;
            v.hit  = 1'($urandom_range(0, 1));
            v.pred = v.pc + (16'($urandom_range(1, 3)) << 4);
            v.rv   = ($urandom_range(0, 9) < 4);
            v.rt   = 1'($urandom_range(0, 1));
            if (mq.size() > 0 && $urandom_range(0, 1) == 1) v.tgt = mq[0].pred_pc;
            else v.tgt = 16'($urandom) & 16'hFFFE;
            apply(v, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
